camera_exposure_ctrl: RTL

Parametrised exposure/readout sequencer for the pixel-array camera. It generalises the fixed two-row exposure controller to NUM_ROWS readout rows, with a programmable, saturating exposure time and a configurable ADC conversion length. The block sits between the user buttons (Init, Exp_increase, Exp_decrease) and the pixel-array/ADC control lines (Erase, Expose, NRE, ADC).

---
 rtl/camera_pkg.sv | 21 ++
 rtl/camera_exp_time_reg.sv | 37 +++
 rtl/camera_exposure_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/camera_pkg.sv
// Shared types and default constants for the camera exposure sequencer.
package camera_pkg;

    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t EXPOSE  = 2'd1;
    localparam state_t READOUT = 2'd2;

    typedef logic [1:0] phase_t;
    localparam phase_t SEL   = 2'd0;
    localparam phase_t CONV  = 2'd1;
    localparam phase_t DESEL = 2'd2;

    localparam int NUM_ROWS_DEF    = 2;
    localparam int EXP_W_DEF       = 5;
    localparam int EXP_MIN_DEF     = 2;
    localparam int EXP_MAX_DEF     = 30;
    localparam int EXP_DEFAULT_DEF = 4;
    localparam int ADC_CYCLES_DEF  = 2;

endpackage

// File: rtl/camera_exp_time_reg.sv
// Saturating up/down exposure-time register, adjustable only while enabled.
module camera_exp_time_reg
    import camera_pkg::*;
#(
    parameter int EXP_W       = EXP_W_DEF,
    parameter int EXP_MIN     = EXP_MIN_DEF,
    parameter int EXP_MAX     = EXP_MAX_DEF,
    parameter int EXP_DEFAULT = EXP_DEFAULT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    output logic [EXP_W-1:0] q
);

    logic up;
    logic dn;

    // Simultaneous inc and dec cancel out.
    assign up = en & inc & ~dec & (q < EXP_W'(EXP_MAX));
    assign dn = en & dec & ~inc & (q > EXP_W'(EXP_MIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= EXP_W'(EXP_DEFAULT);
        end else begin
            unique case (1'b1)
                up:      q <= q + 1'b1;
                dn:      q <= q - 1'b1;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/camera_exposure_ctrl.sv
// Exposure/readout sequencer: IDLE -> EXPOSE -> READOUT over NUM_ROWS rows.
// Define CAMERA_CONTINUOUS_EN to add the Continuous free-running input.
module camera_exposure_ctrl
    import camera_pkg::*;
#(
    parameter int NUM_ROWS    = NUM_ROWS_DEF,
    parameter int EXP_W       = EXP_W_DEF,
    parameter int EXP_MIN     = EXP_MIN_DEF,
    parameter int EXP_MAX     = EXP_MAX_DEF,
    parameter int EXP_DEFAULT = EXP_DEFAULT_DEF,
    parameter int ADC_CYCLES  = ADC_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                Reset,
`ifdef CAMERA_CONTINUOUS_EN
    input  logic                Continuous,
`endif
    input  logic                Init,
    input  logic                Exp_increase,
    input  logic                Exp_decrease,
    output logic                Erase,
    output logic                Expose,
    output logic                ADC,
    output logic [NUM_ROWS-1:0] NRE,
    output logic                Start,
    output logic                Done,
    output logic                Busy,
    output logic [EXP_W-1:0]    Exp_time
);

    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int AW = $clog2(ADC_CYCLES + 1);

    state_t            st_q, st_d;
    phase_t            ph_q, ph_d;
    logic [RW-1:0]     row_q, row_d;
    logic [EXP_W-1:0]  ecnt_q, ecnt_d;
    logic [AW-1:0]     acnt_q, acnt_d;
    logic [NUM_ROWS-1:0] nre_d;
    logic              cont;
    logic              start_req;

`ifdef CAMERA_CONTINUOUS_EN
    assign cont = Continuous & Done;
`else
    assign cont = 1'b0;
`endif

    assign start_req = Init | cont;

    camera_exp_time_reg #(
        .EXP_W       (EXP_W),
        .EXP_MIN     (EXP_MIN),
        .EXP_MAX     (EXP_MAX),
        .EXP_DEFAULT (EXP_DEFAULT)
    ) u_exp (
        .clk   (clk),
        .rst_n (Reset),
        .en    (st_q == IDLE),
        .inc   (Exp_increase),
        .dec   (Exp_decrease),
        .q     (Exp_time)
    );

    always_comb begin
        st_d   = st_q;
        ph_d   = ph_q;
        row_d  = row_q;
        ecnt_d = ecnt_q;
        acnt_d = acnt_q;
        unique case (st_q)
            IDLE: begin
                // Frame latches the pre-adjustment exposure value.
                if (start_req) begin
                    st_d   = EXPOSE;
                    ecnt_d = Exp_time;
                end
            end
            EXPOSE: begin
                if (ecnt_q <= EXP_W'(1)) begin
                    st_d  = READOUT;
                    ph_d  = SEL;
                    row_d = '0;
                end else begin
                    ecnt_d = ecnt_q - 1'b1;
                end
            end
            READOUT: begin
                unique case (ph_q)
                    SEL: begin
                        ph_d   = CONV;
                        acnt_d = AW'(ADC_CYCLES);
                    end
                    CONV: begin
                        if (acnt_q <= AW'(1))
                            ph_d = DESEL;
                        else
                            acnt_d = acnt_q - 1'b1;
                    end
                    default: begin
                        if (row_q == RW'(NUM_ROWS - 1)) begin
                            st_d = IDLE;
                        end else begin
                            row_d = row_q + 1'b1;
                            ph_d  = SEL;
                        end
                    end
                endcase
            end
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        nre_d = '1;
        if (st_d == READOUT && ph_d != DESEL)
            nre_d[row_d] = 1'b0;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            st_q   <= IDLE;
            ph_q   <= SEL;
            row_q  <= '0;
            ecnt_q <= '0;
            acnt_q <= '0;
            Erase  <= 1'b1;
            Expose <= 1'b0;
            ADC    <= 1'b0;
            NRE    <= '1;
            Start  <= 1'b0;
            Done   <= 1'b0;
            Busy   <= 1'b0;
        end else begin
            st_q   <= st_d;
            ph_q   <= ph_d;
            row_q  <= row_d;
            ecnt_q <= ecnt_d;
            acnt_q <= acnt_d;
            Erase  <= (st_d == IDLE);
            Expose <= (st_d == EXPOSE);
            ADC    <= (st_d == READOUT) && (ph_d == CONV);
            NRE    <= nre_d;
            Start  <= (st_q == IDLE) && (st_d == EXPOSE);
            Done   <= (st_q == READOUT) && (st_d == IDLE);
            Busy   <= (st_d != IDLE);
        end
    end

endmodule
